mem_packet_reader: RTL and testbench
====================================

MEM_PACKET_READER -- requirements
Module: mem_packet_reader

Interface
REQ-001 Parameter pBITS, default 8, data word width of the attached register file.
REQ-002 Parameter pWIDHT, default 4, address width; memory depth is 2**pWIDHT words.
REQ-003 iclk  in  1  single clock; all state updates on its rising edge.
REQ-004 irst_n  in  1  reset, synchronous and active-low.
REQ-005 istart  in  1  packet read request; sampled only while obusy is low.
REQ-006 istart_addr  in  pWIDHT  address of the first word of the packet.
REQ-007 ilen  in  pWIDHT+1  packet length in words.
REQ-008 or_addr  out  pWIDHT  read address driven to the register file.
REQ-009 ir_data  in  pBITS  register file read data, combinational from or_addr in the same cycle.
REQ-010 odata  out  pBITS  stream data word.
REQ-011 ovalid  out  1  odata/osop/oeop valid.
REQ-012 iready  in  1  downstream accepts word; a transfer occurs when ovalid and iready are both high at an edge.
REQ-013 osop  out  1  first word of the packet.
REQ-014 oeop  out  1  last word of the packet.
REQ-015 obusy  out  1  packet in progress.
REQ-016 odone  out  1  one-cycle pulse after the last word transfers.

Function
REQ-017 The FSM states are IDLE, READ and LAST, with transitions as follows:
- IDLE -> READ on istart=1 with ilen!=0.
- READ -> LAST once the final word is loaded into the output register.
- LAST -> IDLE on the final word transfer.
REQ-018 In IDLE, istart with ilen=0 shall be ignored: no state change, no outputs.
REQ-019 An ilen value greater than 2**pWIDHT shall saturate to 2**pWIDHT.
REQ-020 On accept, the block shall latch the address counter (=istart_addr) and the remaining counter (=ilen), and obusy shall rise at that edge.
REQ-021 The output register shall load ir_data at or_addr when ovalid=0, or when ovalid=1 and iready=1, while remaining!=0.
REQ-022 Each load shall decrement remaining by 1 and increment the address counter modulo 2**pWIDHT (wrap from 2**pWIDHT-1 to 0).
REQ-023 Latency: istart high in cycle N -> ovalid high in cycle N+2.
REQ-024 With iready held high the block shall sustain one word per cycle with no bubbles.
REQ-025 While ovalid=1 and iready=0, odata, osop and oeop shall hold stable and no load shall occur.
REQ-026 osop=1 shall accompany only the first word and oeop=1 only the last; for ilen=1 both shall be 1 on the same word.
REQ-027 After the final transfer edge: ovalid=0, obusy=0, and odone=1 for exactly one cycle.
REQ-028 istart while obusy=1 shall be ignored, including in the cycle of the final transfer.
REQ-029 istart in the cycle odone=1 shall be accepted.
REQ-030 or_addr shall equal the address counter at all times.

Reset
REQ-031 irst_n=0 at an edge shall force IDLE and clear ovalid, osop, oeop, obusy, odone, odata, or_addr and both counters to 0.
REQ-032 Reset mid-packet shall drop the packet silently with no odone; the first istart after reset release shall be accepted normally.

Structure
REQ-033 FSM state encodings and parameter defaults shall live in the shared package/header used by the memory blocks.
REQ-034 The output holding register (data, osop, oeop, valid, load/hold logic) shall be a sub-module named stream_out_reg.
REQ-035 The block shall contain no memory array; it connects to a reg_file-style async-read port.

Verification
REQ-036 Bench memory model: reg_file preloaded with word[i]=i+8'h10.
REQ-037 Basic read, iready=1, istart_addr=2, ilen=4 -> words 12,13,14,15 in consecutive cycles starting N+2; osop on 12, oeop on 15, odone one cycle after.
REQ-038 Wrap-around, istart_addr=14, ilen=4 -> words 1E,1F,10,11.
REQ-039 Backpressure, ilen=3, iready toggled 1,0,0,1,... -> data held stable while stalled; exactly 3 transfers; no duplicated or lost words.
REQ-040 Boundary lengths:
- ilen=1 -> single word with osop=oeop=1.
- ilen=0 -> no activity.
- ilen=31 -> 16 words.
REQ-041 Collisions: istart during busy is ignored; istart in the odone cycle starts a new packet.
REQ-042 Reset after the 2nd of 6 words -> all outputs 0 next cycle; no odone; the following packet is correct.

Source files
------------

// File: rtl/mem_packet_reader_pkg.sv
// Shared definitions for the memory-side packet blocks.
// Holds the reader FSM encoding and the default geometry.
package mem_packet_reader_pkg;

  localparam int DEF_BITS  = 8;
  localparam int DEF_WIDHT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_LAST = 2'd2
  } rd_state_e;

endpackage

// File: rtl/stream_out_reg.sv
// Output holding register for the packet stream.
// Loads a word on request, drops valid on handshake, else holds.
module stream_out_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         sop_i,
  input  logic         eop_i,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         sop_o,
  output logic         eop_o
);

  logic [W-1:0] data_q;
  logic         valid_q;
  logic         sop_q;
  logic         eop_q;

  // Fresh word on load; drain when accepted with nothing behind it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
      sop_q   <= sop_i;
      eop_q   <= eop_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign sop_o   = sop_q;
  assign eop_o   = eop_q;

endmodule

// File: rtl/mem_packet_reader.sv
// Streams a packet of words out of an async-read register file.
// FSM walks the address range; stream_out_reg holds the words.
module mem_packet_reader
  import mem_packet_reader_pkg::*;
#(
  parameter int pBITS  = DEF_BITS,
  parameter int pWIDHT = DEF_WIDHT
) (
  input  logic              iclk,
  input  logic              irst_n,
  input  logic              istart,
  input  logic [pWIDHT-1:0] istart_addr,
  input  logic [pWIDHT:0]   ilen,
  output logic [pWIDHT-1:0] or_addr,
  input  logic [pBITS-1:0]  ir_data,
  output logic [pBITS-1:0]  odata,
  output logic              ovalid,
  input  logic              iready,
  output logic              osop,
  output logic              oeop,
  output logic              obusy,
  output logic              odone
);

  localparam logic [pWIDHT:0] MAXLEN = {1'b1, {pWIDHT{1'b0}}};
  localparam logic [pWIDHT:0] ONE    = (pWIDHT+1)'(1);

  rd_state_e         state_q;
  logic [pWIDHT-1:0] addr_q;
  logic [pWIDHT:0]   rem_q;
  logic              first_q;
  logic              busy_q;
  logic              done_q;

  logic              valid;
  logic              load;
  logic              xfer;
  logic              last_word;

  assign xfer      = valid && iready;
  assign last_word = (rem_q == ONE);
  assign load      = (state_q == ST_READ) &&
                     (rem_q != '0) &&
                     (!valid || iready);

  // Packet sequencing: accept, walk addresses, close on last handshake.
  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      first_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (istart && (ilen != '0)) begin
            state_q <= ST_READ;
            addr_q  <= istart_addr;
            rem_q   <= (ilen > MAXLEN) ? MAXLEN : ilen;
            first_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_READ: begin
          if (load) begin
            addr_q  <= addr_q + pWIDHT'(1);
            rem_q   <= rem_q - ONE;
            first_q <= 1'b0;
            if (last_word) begin
              state_q <= ST_LAST;
            end
          end
        end
        ST_LAST: begin
          if (xfer) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  stream_out_reg #(
    .W (pBITS)
  ) u_out (
    .clk_i   (iclk),
    .rst_ni  (irst_n),
    .load_i  (load),
    .data_i  (ir_data),
    .sop_i   (first_q),
    .eop_i   (last_word),
    .ready_i (iready),
    .data_o  (odata),
    .valid_o (valid),
    .sop_o   (osop),
    .eop_o   (oeop)
  );

  assign ovalid  = valid;
  assign or_addr = addr_q;
  assign obusy   = busy_q;
  assign odone   = done_q;

endmodule

// File: tb/tb_mem_packet_reader.sv
// Directed bench for mem_packet_reader.
// A queue-based packet model is checked against the DUT every cycle.
module tb_mem_packet_reader;

  localparam int B = 8;
  localparam int A = 4;

  logic         iclk = 1'b0;
  logic         irst_n;
  logic         istart;
  logic         iready;
  logic [A-1:0] istart_addr;
  logic [A:0]   ilen;
  logic [A-1:0] or_addr;
  logic [B-1:0] ir_data;
  logic [B-1:0] odata;
  logic         ovalid;
  logic         osop;
  logic         oeop;
  logic         obusy;
  logic         odone;

  logic [B-1:0] mem [16];

  mem_packet_reader #(
    .pBITS  (B),
    .pWIDHT (A)
  ) dut (
    .iclk        (iclk),
    .irst_n      (irst_n),
    .istart      (istart),
    .istart_addr (istart_addr),
    .ilen        (ilen),
    .or_addr     (or_addr),
    .ir_data     (ir_data),
    .odata       (odata),
    .ovalid      (ovalid),
    .iready      (iready),
    .osop        (osop),
    .oeop        (oeop),
    .obusy       (obusy),
    .odone       (odone)
  );

  assign ir_data = mem[or_addr];

  always #5 iclk = ~iclk;

  int nchk = 0;
  int nerr = 0;
  int cyc_cnt = 0;
  int done_cnt = 0;
  int t0 = 0;
  bit chk_en = 1'b0;

  // model state: expected words as {sop, eop, data}
  logic [9:0] q[$];
  bit busy_m = 1'b0;
  bit warm_m = 1'b0;
  bit done_m = 1'b0;
  int len_m;

  // observed transfers
  logic [9:0] got[$];
  int got_cyc[$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] word_at(input int a);
    return 8'h10 + 8'(a % 16);
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(i) + 8'h10;
  end

  initial forever begin
    @(posedge iclk);
    cyc_cnt++;
  end

  // Compare and model step, away from the active edge.
  initial forever begin
    @(negedge iclk);
    if (chk_en) begin
      check("obusy", 32'(obusy), 32'(busy_m));
      check("odone", 32'(odone), 32'(done_m));
      check("ovalid", 32'(ovalid), 32'(busy_m && warm_m));
      if (busy_m && warm_m && q.size() > 0)
        check("word", 32'({osop, oeop, odata}), 32'(q[0]));
      if (odone === 1'b1) done_cnt++;
      if (irst_n && ovalid && iready) begin
        got.push_back({osop, oeop, odata});
        got_cyc.push_back(cyc_cnt);
      end
    end
    if (!irst_n) begin
      q.delete();
      busy_m = 1'b0;
      warm_m = 1'b0;
      done_m = 1'b0;
    end else begin
      done_m = 1'b0;
      if (busy_m && !warm_m) begin
        warm_m = 1'b1;
      end else if (busy_m) begin
        if (iready) begin
          void'(q.pop_front());
          if (q.size() == 0) begin
            busy_m = 1'b0;
            warm_m = 1'b0;
            done_m = 1'b1;
          end
        end
      end else if (istart && ilen != 0) begin
        len_m = (int'(ilen) > 16) ? 16 : int'(ilen);
        for (int k = 0; k < len_m; k++)
          q.push_back({k == 0, k == len_m - 1,
                       word_at(int'(istart_addr) + k)});
        busy_m = 1'b1;
        warm_m = 1'b0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge iclk);
    #1;
  endtask

  task automatic start(input int a, input int l);
    istart      = 1'b1;
    istart_addr = A'(a);
    ilen        = (A+1)'(l);
    t0          = cyc_cnt;
    cyc(1);
    istart      = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      cyc(1);
      if (odone) seen = 1'b1;
    end
    check("done_timeout", 32'(seen), 32'd1);
    cyc(1);
  endtask

  task automatic clr();
    got.delete();
    got_cyc.delete();
    iready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] pat = 4'b1001;
  int saved;
  bit seen;

  initial begin
    irst_n = 1'b0;
    istart = 1'b0;
    iready = 1'b0;
    istart_addr = '0;
    ilen = '0;
    cyc(2);
    check("rst_state",
          32'({ovalid, osop, oeop, obusy, odone, odata, or_addr}),
          32'd0);
    irst_n = 1'b1;
    chk_en = 1'b1;
    cyc(1);

    // basic
    clr();
    start(2, 4);
    wait_done(20);
    check("basic_n", 32'(got.size()), 32'd4);
    check("basic_w0", 32'(got[0]), 32'h212);
    check("basic_w1", 32'(got[1]), 32'h013);
    check("basic_w2", 32'(got[2]), 32'h014);
    check("basic_w3", 32'(got[3]), 32'h115);
    check("basic_lat", 32'(got_cyc[0] - t0), 32'd2);
    check("basic_nobub", 32'(got_cyc[3] - got_cyc[0]), 32'd3);
    check("basic_done", 32'(done_cnt), 32'd1);

    // wrap-around
    clr();
    start(14, 4);
    wait_done(20);
    check("wrap_n", 32'(got.size()), 32'd4);
    check("wrap_w0", 32'(got[0]), 32'h21E);
    check("wrap_w1", 32'(got[1]), 32'h01F);
    check("wrap_w2", 32'(got[2]), 32'h010);
    check("wrap_w3", 32'(got[3]), 32'h111);

    // backpressure
    clr();
    start(5, 3);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      iready = pat[i % 4];
      cyc(1);
      if (odone) seen = 1'b1;
    end
    check("bp_timeout", 32'(seen), 32'd1);
    iready = 1'b1;
    cyc(1);
    check("bp_n", 32'(got.size()), 32'd3);
    check("bp_w0", 32'(got[0]), 32'h215);
    check("bp_w1", 32'(got[1]), 32'h016);
    check("bp_w2", 32'(got[2]), 32'h117);

    // single word
    clr();
    start(9, 1);
    wait_done(20);
    check("one_n", 32'(got.size()), 32'd1);
    check("one_w0", 32'(got[0]), 32'h319);

    // zero length
    clr();
    saved = done_cnt;
    start(3, 0);
    cyc(6);
    check("zero_n", 32'(got.size()), 32'd0);
    check("zero_busy", 32'(obusy), 32'd0);
    check("zero_done", 32'(done_cnt), 32'(saved));

    // oversize length saturates
    clr();
    start(0, 31);
    wait_done(40);
    check("big_n", 32'(got.size()), 32'd16);
    check("big_w0", 32'(got[0]), 32'h210);
    check("big_w7", 32'(got[7]), 32'h017);
    check("big_w15", 32'(got[15]), 32'h11F);

    // collisions
    clr();
    start(0, 3);
    istart = 1'b1;
    istart_addr = 4'd8;
    ilen = 5'd2;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      cyc(1);
      if (odone) seen = 1'b1;
    end
    check("col_timeout", 32'(seen), 32'd1);
    cyc(1);
    istart = 1'b0;
    wait_done(20);
    check("col_n", 32'(got.size()), 32'd5);
    check("col_w0", 32'(got[0]), 32'h210);
    check("col_w2", 32'(got[2]), 32'h112);
    check("col_w3", 32'(got[3]), 32'h218);
    check("col_w4", 32'(got[4]), 32'h119);

    // reset mid-packet
    clr();
    start(0, 6);
    for (int i = 0; i < 20 && got.size() < 2; i++) cyc(1);
    check("mid_n", 32'(got.size()), 32'd2);
    saved = done_cnt;
    irst_n = 1'b0;
    cyc(1);
    check("mid_rst",
          32'({ovalid, osop, oeop, obusy, odone, odata, or_addr}),
          32'd0);
    irst_n = 1'b1;
    cyc(3);
    check("mid_nodone", 32'(done_cnt), 32'(saved));
    clr();
    start(4, 2);
    wait_done(20);
    check("post_n", 32'(got.size()), 32'd2);
    check("post_w0", 32'(got[0]), 32'h214);
    check("post_w1", 32'(got[1]), 32'h115);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
